// File: rtl/gtp_pkg.sv
// Shared types and default timing for the GTPE2_COMMON PLL0 reset sequencer.
package gtp_pkg;

  localparam int unsigned PD_CYCLES_DEF    = 32;
  localparam int unsigned RST_CYCLES_DEF   = 8;
  localparam int unsigned LOCK_TIMEOUT_DEF = 4096;
  localparam int unsigned LOSS_FILTER_DEF  = 4;
  localparam int unsigned MAX_RETRIES_DEF  = 3;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;

  localparam logic [STATE_W-1:0] ST_PWRDN     = 3'd0;
  localparam logic [STATE_W-1:0] ST_RESET     = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOCKED    = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAIL      = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_PWRDN     = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_LOCKED    = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gtp_common_reset_seq_if.sv
// Control/status bundle between the PLL0 reset sequencer and its environment.
interface gtp_common_reset_seq_if;
  import gtp_pkg::*;

  logic               restart;
  logic               pll_lock;
  logic               refclk_lost;
  logic               pll_pd;
  logic               pll_reset;
  logic               done;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [STATE_W-1:0] state_o;

  modport master (
    output restart, pll_lock, refclk_lost,
    input  pll_pd, pll_reset, done, fail, retry_cnt, state_o
  );

  modport slave (
    input  restart, pll_lock, refclk_lost,
    output pll_pd, pll_reset, done, fail, retry_cnt, state_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Plain two-flop synchronizer for quasi-static or slow asynchronous inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gtp_common_reset_seq.sv
// PLL0 power-down / reset / lock-wait sequencer for GTPE2_COMMON with bounded retries.
module gtp_common_reset_seq
  import gtp_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = PD_CYCLES_DEF,
  parameter int unsigned RST_CYCLES   = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned LOSS_FILTER  = LOSS_FILTER_DEF,
  parameter int unsigned MAX_RETRIES  = MAX_RETRIES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gtp_common_reset_seq_if.slave bus
);

  localparam int unsigned CNT_W  = cnt_width(max3(PD_CYCLES, RST_CYCLES, LOCK_TIMEOUT));
  localparam int unsigned LOSS_W = cnt_width(LOSS_FILTER);

  logic [1:0]         w_sync_in;
  logic [1:0]         w_sync_out;
  logic               w_lock_s;
  logic               w_lost_s;

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LOSS_W-1:0]  r_loss;
  logic [RETRY_W-1:0] r_retry;
  logic               r_pll_pd;
  logic               r_pll_reset;
  logic               r_done;
  logic               r_fail;

  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LOSS_W-1:0]  w_loss_nxt;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               w_attempt_fail;

  assign w_sync_in = {bus.refclk_lost, bus.pll_lock};

  sync_2ff #(
    .WIDTH (2)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_sync_in),
    .o_q   (w_sync_out)
  );

  assign w_lock_s = w_sync_out[0];
  assign w_lost_s = w_sync_out[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PWRDN;
      r_cnt       <= '0;
      r_loss      <= '0;
      r_retry     <= '0;
      r_pll_pd    <= 1'b1;
      r_pll_reset <= 1'b1;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_loss      <= w_loss_nxt;
      r_retry     <= w_retry_nxt;
      // Outputs decode the next state so they change on the same edge as the state.
      r_pll_pd    <= (w_state_nxt == ST_PWRDN) || (w_state_nxt == ST_FAIL);
      r_pll_reset <= (w_state_nxt != ST_WAIT_LOCK) && (w_state_nxt != ST_LOCKED);
      r_done      <= (w_state_nxt == ST_LOCKED);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + CNT_W'(1);
    w_loss_nxt     = '0;
    w_retry_nxt    = r_retry;
    w_attempt_fail = 1'b0;

    case (r_state)
      ST_PWRDN: begin
        w_retry_nxt = '0;
        if (r_cnt == CNT_W'(PD_CYCLES - 1)) begin
          w_state_nxt = ST_RESET;
          w_cnt_nxt   = '0;
        end
      end
      ST_RESET: begin
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s && !w_lost_s) begin
          w_state_nxt = ST_LOCKED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_attempt_fail = 1'b1;
        end
      end
      ST_LOCKED: begin
        w_cnt_nxt = '0;
        // Reference loss is immediate; lock loss must persist LOSS_FILTER cycles.
        if (w_lost_s) begin
          w_attempt_fail = 1'b1;
        end else if (!w_lock_s) begin
          if (r_loss == LOSS_W'(LOSS_FILTER - 1)) begin
            w_attempt_fail = 1'b1;
          end else begin
            w_loss_nxt = r_loss + LOSS_W'(1);
          end
        end
      end
      ST_FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_PWRDN;
        w_cnt_nxt   = '0;
      end
    endcase

    // A failed attempt retries from RESET until the retry budget is spent.
    if (w_attempt_fail) begin
      w_cnt_nxt  = '0;
      w_loss_nxt = '0;
      if (r_retry >= RETRY_W'(MAX_RETRIES)) begin
        w_state_nxt = ST_FAIL;
      end else begin
        w_state_nxt = ST_RESET;
        w_retry_nxt = r_retry + RETRY_W'(1);
      end
    end

    if (bus.restart) begin
      w_state_nxt = ST_PWRDN;
      w_cnt_nxt   = '0;
      w_loss_nxt  = '0;
      w_retry_nxt = '0;
    end
  end

  assign bus.pll_pd    = r_pll_pd;
  assign bus.pll_reset = r_pll_reset;
  assign bus.done      = r_done;
  assign bus.fail      = r_fail;
  assign bus.retry_cnt = r_retry;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_gtp_common_reset_seq.sv
// Directed bench for the PLL0 reset sequencer using default timing parameters.
module tb_gtp_common_reset_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  gtp_common_reset_seq_if u_if ();

  gtp_common_reset_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.restart = 1'b0; u_if.pll_lock = 1'b0; u_if.refclk_lost = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (u_if.state_o !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", u_if.state_o); end
    n_tests++; if (u_if.pll_pd !== 1'b1 || u_if.pll_reset !== 1'b1) begin n_fail++; $display("FAIL rst_pd_reset: got pd=%b rst=%b want 1 1", u_if.pll_pd, u_if.pll_reset); end
    n_tests++; if (u_if.done !== 1'b0 || u_if.fail !== 1'b0 || u_if.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_status: got done=%b fail=%b retry=%0d want 0 0 0", u_if.done, u_if.fail, u_if.retry_cnt); end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_lock_seq();
    step_to(31);
    n_tests++; if (u_if.pll_pd !== 1'b1) begin n_fail++; $display("FAIL pd_c31: got %b want 1", u_if.pll_pd); end
    step_to(32);
    n_tests++; if (u_if.pll_pd !== 1'b0 || u_if.pll_reset !== 1'b1 || u_if.state_o !== 3'd1) begin n_fail++; $display("FAIL pd_fall_c32: got pd=%b rst=%b st=%0d want 0 1 1", u_if.pll_pd, u_if.pll_reset, u_if.state_o); end
    step_to(39);
    n_tests++; if (u_if.pll_reset !== 1'b1) begin n_fail++; $display("FAIL rst_c39: got %b want 1", u_if.pll_reset); end
    step_to(40);
    n_tests++; if (u_if.pll_reset !== 1'b0 || u_if.state_o !== 3'd2) begin n_fail++; $display("FAIL rst_fall_c40: got rst=%b st=%0d want 0 2", u_if.pll_reset, u_if.state_o); end
    step_to(60);
    u_if.pll_lock = 1'b1;
    step_to(62);
    n_tests++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL done_c62: got %b want 0", u_if.done); end
    step_to(63);
    n_tests++; if (u_if.done !== 1'b1 || u_if.state_o !== 3'd3 || u_if.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL done_c63: got done=%b st=%0d retry=%0d want 1 3 0", u_if.done, u_if.state_o, u_if.retry_cnt); end
  endtask

  task automatic test_loss_filter();
    int low_cycles;
    step_to(70);
    u_if.pll_lock = 1'b0;
    step_to(73);
    u_if.pll_lock = 1'b1;
    low_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step1();
      if (u_if.done !== 1'b1) low_cycles++;
    end
    n_tests++; if (low_cycles !== 0) begin n_fail++; $display("FAIL glitch3_done: done low %0d cycles want 0", low_cycles); end
    step_to(81);
    u_if.pll_lock = 1'b0;
    step_to(85);
    u_if.pll_lock = 1'b1;
    step_to(86);
    n_tests++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL loss4_c86: got done=%b want 1", u_if.done); end
    step_to(87);
    n_tests++; if (u_if.done !== 1'b0 || u_if.pll_reset !== 1'b1 || u_if.state_o !== 3'd1 || u_if.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL loss4_c87: got done=%b rst=%b st=%0d retry=%0d want 0 1 1 1", u_if.done, u_if.pll_reset, u_if.state_o, u_if.retry_cnt); end
    step_to(96);
    n_tests++; if (u_if.done !== 1'b1 || u_if.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL relock_c96: got done=%b retry=%0d want 1 1", u_if.done, u_if.retry_cnt); end
  endtask

  task automatic test_refclk_lost();
    step_to(100);
    u_if.refclk_lost = 1'b1;
    step_to(101);
    u_if.refclk_lost = 1'b0;
    step_to(102);
    n_tests++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL lost_c102: got done=%b want 1", u_if.done); end
    step_to(103);
    n_tests++; if (u_if.done !== 1'b0 || u_if.state_o !== 3'd1 || u_if.retry_cnt !== 2'd2) begin n_fail++; $display("FAIL lost_c103: got done=%b st=%0d retry=%0d want 0 1 2", u_if.done, u_if.state_o, u_if.retry_cnt); end
  endtask

  task automatic test_async_reset();
    step_to(104);
    n_tests++; if (u_if.state_o !== 3'd1) begin n_fail++; $display("FAIL arst_pre: got st=%0d want 1", u_if.state_o); end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (u_if.state_o !== 3'd0 || u_if.pll_pd !== 1'b1 || u_if.pll_reset !== 1'b1) begin n_fail++; $display("FAIL arst_now: got st=%0d pd=%b rst=%b want 0 1 1", u_if.state_o, u_if.pll_pd, u_if.pll_reset); end
    n_tests++; if (u_if.done !== 1'b0 || u_if.fail !== 1'b0 || u_if.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL arst_status: got done=%b fail=%b retry=%0d want 0 0 0", u_if.done, u_if.fail, u_if.retry_cnt); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step_to(31);
    n_tests++; if (u_if.pll_pd !== 1'b1) begin n_fail++; $display("FAIL arst_pd_c31: got %b want 1", u_if.pll_pd); end
    step_to(32);
    n_tests++; if (u_if.pll_pd !== 1'b0) begin n_fail++; $display("FAIL arst_pd_c32: got %b want 0", u_if.pll_pd); end
    step_to(41);
    n_tests++; if (u_if.done !== 1'b1 || u_if.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL arst_done_c41: got done=%b retry=%0d want 1 0", u_if.done, u_if.retry_cnt); end
  endtask

  task automatic test_restart_wait();
    step_to(50);
    u_if.pll_lock = 1'b0;
    step_to(56);
    n_tests++; if (u_if.state_o !== 3'd1 || u_if.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL rw_reset_c56: got st=%0d retry=%0d want 1 1", u_if.state_o, u_if.retry_cnt); end
    step_to(65);
    n_tests++; if (u_if.state_o !== 3'd2) begin n_fail++; $display("FAIL rw_wait_c65: got st=%0d want 2", u_if.state_o); end
    u_if.restart = 1'b1;
    step_to(66);
    u_if.restart = 1'b0;
    n_tests++; if (u_if.state_o !== 3'd0 || u_if.pll_pd !== 1'b1 || u_if.retry_cnt !== 2'd0 || u_if.fail !== 1'b0) begin n_fail++; $display("FAIL rw_pwrdn: got st=%0d pd=%b retry=%0d fail=%b want 0 1 0 0", u_if.state_o, u_if.pll_pd, u_if.retry_cnt, u_if.fail); end
  endtask

  task automatic test_fail();
    int base;
    base = 66;
    step_to(base + 4136);
    n_tests++; if (u_if.state_o !== 3'd1 || u_if.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL to1: got st=%0d retry=%0d want 1 1", u_if.state_o, u_if.retry_cnt); end
    step_to(base + 16447);
    n_tests++; if (u_if.fail !== 1'b0 || u_if.state_o !== 3'd2 || u_if.retry_cnt !== 2'd3) begin n_fail++; $display("FAIL pre_fail: got fail=%b st=%0d retry=%0d want 0 2 3", u_if.fail, u_if.state_o, u_if.retry_cnt); end
    step_to(base + 16448);
    n_tests++; if (u_if.fail !== 1'b1 || u_if.pll_pd !== 1'b1 || u_if.retry_cnt !== 2'd3 || u_if.state_o !== 3'd4 || u_if.done !== 1'b0) begin n_fail++; $display("FAIL in_fail: got fail=%b pd=%b retry=%0d st=%0d done=%b want 1 1 3 4 0", u_if.fail, u_if.pll_pd, u_if.retry_cnt, u_if.state_o, u_if.done); end
    u_if.pll_lock = 1'b1;
    step_to(base + 16468);
    n_tests++; if (u_if.state_o !== 3'd4 || u_if.fail !== 1'b1) begin n_fail++; $display("FAIL fail_sticky: got st=%0d fail=%b want 4 1", u_if.state_o, u_if.fail); end
  endtask

  task automatic test_restart_fail();
    u_if.restart = 1'b1;
    step1();
    u_if.restart = 1'b0;
    n_tests++; if (u_if.state_o !== 3'd0 || u_if.pll_pd !== 1'b1 || u_if.pll_reset !== 1'b1) begin n_fail++; $display("FAIL rf_state: got st=%0d pd=%b rst=%b want 0 1 1", u_if.state_o, u_if.pll_pd, u_if.pll_reset); end
    n_tests++; if (u_if.fail !== 1'b0 || u_if.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL rf_status: got fail=%b retry=%0d want 0 0", u_if.fail, u_if.retry_cnt); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    test_reset();
    test_lock_seq();
    test_loss_filter();
    test_refclk_lost();
    test_async_reset();
    test_restart_wait();
    test_fail();
    test_restart_fail();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gtp_common_reset_seq.md
GTP_COMMON_RESET_SEQ -- requirements
Module: gtp_common_reset_seq

Interface
REQ-001 SHALL have parameter PD_CYCLES, default 32: cycles PLL0PD is held high after reset or restart.
REQ-002 SHALL have parameter RST_CYCLES, default 8: cycles PLL0RESET is held high per attempt.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles to wait for lock before an attempt fails.
REQ-004 SHALL have parameter LOSS_FILTER, default 4: consecutive unlocked cycles that count as loss of lock.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: failed attempts allowed before FAIL.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port restart, input, 1: synchronous pulse; restarts from power-down.
REQ-009 SHALL have port pll_lock, input, 1: PLL0LOCK from GTPE2_COMMON; asynchronous to clk.
REQ-010 SHALL have port refclk_lost, input, 1: PLL0REFCLKLOST; asynchronous to clk.
REQ-011 SHALL have port pll_pd, output, 1: drives PLL0PD.
REQ-012 SHALL have port pll_reset, output, 1: drives PLL0RESET.
REQ-013 SHALL have port done, output, 1: PLL locked and stable.
REQ-014 SHALL have port fail, output, 1: retries exhausted.
REQ-015 SHALL have port retry_cnt, output, 2: failed attempts since last power-down.
REQ-016 SHALL have port state_o, output, 3: current state encoding, for debug.

Function
REQ-017 SHALL pass pll_lock and refclk_lost each through a 2-flop synchronizer before use; this adds 2 cycles of input latency.
REQ-018 SHALL implement the states PWRDN, RESET, WAIT_LOCK, LOCKED and FAIL, held in one shared cycle counter plus the state register.
REQ-019 PWRDN SHALL drive pll_pd=1 and pll_reset=1 for PD_CYCLES cycles, clear retry_cnt, then go to RESET.
REQ-020 RESET SHALL drive pll_pd=0 and pll_reset=1 for RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-021 WAIT_LOCK SHALL go to LOCKED when synced lock=1 and synced refclk_lost=0.
REQ-022 If WAIT_LOCK's counter reaches LOCK_TIMEOUT-1 without lock, it SHALL take one of two paths:
- retry_cnt < MAX_RETRIES: increment retry_cnt and go to RESET.
- retry_cnt = MAX_RETRIES: go to FAIL.
REQ-023 LOCKED SHALL drive done=1.
REQ-024 LOCKED SHALL leave on either event below, incrementing retry_cnt under the REQ-022 rule or going to FAIL:
- synced lock=0 for LOSS_FILTER consecutive cycles;
- synced refclk_lost=1 for 1 cycle.
REQ-025 LOCKED SHALL reset its loss-filter count on any cycle with lock=1, so 1 to LOSS_FILTER-1 cycle glitches are ignored.
REQ-026 FAIL SHALL drive fail=1 and pll_pd=1, and SHALL stay in FAIL until restart.
REQ-027 restart=1 SHALL force PWRDN with the counter cleared on the next edge from any state; it has priority over every other transition.
REQ-028 done and fail SHALL be registered, mutually exclusive and never high simultaneously.
REQ-029 retry_cnt SHALL saturate at MAX_RETRIES and never wrap.
REQ-030 The cycle counter width SHALL be clog2 of the largest of PD_CYCLES, RST_CYCLES and LOCK_TIMEOUT, computed at elaboration.

Reset
REQ-031 While rst_n=0 the block SHALL hold:
- state=PWRDN, counter=0, synchronizers=0;
- pll_pd=1, pll_reset=1;
- done=0, fail=0, retry_cnt=0.
REQ-032 Deassertion of rst_n mid-sequence SHALL restart the full PD_CYCLES power-down, with no carry-over of the retry count.

Structure
REQ-033 A shared package gtp_pkg SHALL hold the state enum and its 3-bit encoding, plus the default timing constants.
REQ-034 The synchronizer SHALL be the sub-module sync_2ff, parameterized width, instantiated once with width 2.
REQ-035 The design SHALL be flat otherwise: one FSM, one counter, one loss-filter counter.

Verification
REQ-036 Reset release, lock rising at cycle 60 -> pll_pd falls at cycle 32, pll_reset falls at cycle 40, done=1 at cycle 63 (60 plus 2 sync cycles plus 1 registered).
REQ-037 lock never asserted -> three retries, then fail=1 at about cycle 40+4×(4096+8); retry_cnt=3 and pll_pd=1 in FAIL.
REQ-038 In LOCKED, lock dropped for 3 cycles -> done stays 1; lock dropped for 4 cycles -> done=0, pll_reset=1, retry_cnt+1.
REQ-039 In LOCKED, refclk_lost pulse of 1 cycle -> RESET 3 cycles later, done=0.
REQ-040 restart asserted in WAIT_LOCK, and separately in FAIL -> next cycle state=PWRDN, pll_pd=1, retry_cnt=0, fail=0.
REQ-041 rst_n asserted during RESET -> outputs reach reset values immediately, without waiting for a clock edge; full sequence repeats after release.
